// File: rtl/uart_tx_prog_pkg.sv
// Shared types and constants for the programmable UART transmitter.
package uart_tx_prog_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_tx_state_t;

  localparam int unsigned DefClkFreq  = 20000000;
  localparam int unsigned DefBaud     = 115200;
  localparam int unsigned DefDivWidth = 16;
  localparam int unsigned DefDivisor  = DefClkFreq / DefBaud - 1;

  localparam logic [31:0] UartBaseAddr = 32'h4000_0000;
  localparam logic [31:0] UartTopAddr  = 32'h4000_00ff;

  // Divisor register value: clocks per bit minus one.
  function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud - 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// DEPTH x 8 circular TX FIFO; count register carries one extra bit so full and empty differ.
module uart_tx_fifo
  import uart_tx_prog_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] count_q;
  logic          do_push, do_pop;

  assign full     = (count_q == LW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem_q[rptr_q];
  assign level    = count_q;

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_tx_prog.sv
// UART transmitter with runtime divisor, TX FIFO and 1/2 stop bits.
// Define UART_TX_PARITY_EN to add a parity bit (parity_odd input, PARITY state).
module uart_tx_prog
  import uart_tx_prog_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = DefClkFreq,
  parameter int unsigned BAUD      = DefBaud,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DIV_WIDTH = DefDivWidth
) (
  input  logic                   reset,
  input  logic                   clock,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  input  logic                   div_wen,
  input  logic [DIV_WIDTH-1:0]   div_wdata,
  input  logic                   stop2,
`ifdef UART_TX_PARITY_EN
  input  logic                   parity_odd,
`endif
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam logic [DIV_WIDTH-1:0] DivReset = DIV_WIDTH'(calc_div(CLK_FREQ, BAUD));

`ifdef UART_TX_PARITY_EN
  localparam uart_tx_state_t AfterData = StParity;
`else
  localparam uart_tx_state_t AfterData = StStop;
`endif

  uart_tx_state_t       state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_lat_q, timer_q;
  logic [2:0]           bit_cnt_q;
  logic [7:0]           shift_q;
  logic                 stop2_q;
  logic                 tx_q, tx_d;
  logic                 frame_start, bit_done;
  logic [7:0]           fifo_data;
  logic                 fifo_full, fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic                 par_q;
`endif

  uart_tx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (in_valid),
    .push_data(in_data),
    .pop      (frame_start),
    .pop_data (fifo_data),
    .level    (level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign in_ready = ~fifo_full;
  assign bit_done = (timer_q == '0);
  assign busy     = (state_q != StIdle) | (level != '0);
  assign tx       = tx_q;

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    tx_d        = 1'b1;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          frame_start = 1'b1;
          state_d     = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (bit_done) state_d = StData;
      end
      StData: begin
        tx_d = shift_q[0];
        if (bit_done && bit_cnt_q == 3'd7) state_d = AfterData;
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        tx_d = par_q;
        if (bit_done) state_d = StStop;
      end
`endif
      StStop: begin
        // bit_cnt_q counts stop-bit periods; chain straight into the next frame if data waits.
        if (bit_done && bit_cnt_q == {2'b00, stop2_q}) begin
          if (!fifo_empty) begin
            frame_start = 1'b1;
            state_d     = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      tx_q    <= 1'b1;
      div_q   <= DivReset;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      if (div_wen) div_q <= div_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q   <= '0;
      div_lat_q <= '0;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      stop2_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else if (frame_start) begin
      shift_q   <= fifo_data;
      div_lat_q <= div_q;
      timer_q   <= div_q;
      bit_cnt_q <= '0;
      stop2_q   <= stop2;
`ifdef UART_TX_PARITY_EN
      par_q     <= (^fifo_data) ^ parity_odd;
`endif
    end else if (state_q != StIdle) begin
      if (bit_done) begin
        timer_q <= div_lat_q;
        // Data count wraps 7 -> 0, so the stop phase starts counting from zero.
        if (state_q == StData) begin
          shift_q   <= shift_q >> 1;
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end else if (state_q == StStop) begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
      end else begin
        timer_q <= timer_q - DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_prog.sv
// Self-checking bench for uart_tx_prog: tx waveform compared against a bit-level frame model.
module tb_uart_tx_prog;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        div_wen = 1'b0;
  logic [15:0] div_wdata = 16'h0;
  logic        stop2 = 1'b0;
`ifdef UART_TX_PARITY_EN
  logic        parity_odd = 1'b0;
`endif
  logic        tx, busy;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic       exp_q[$];
  logic       cap_tx[4096];
  logic       cap_busy[4096];
  logic       cap_rdy[4096];
  logic [2:0] cap_level[4096];

  uart_tx_prog #(
    .CLK_FREQ (20000000),
    .BAUD     (115200),
    .DEPTH    (4),
    .DIV_WIDTH(16)
  ) dut (
    .reset    (reset),
    .clock    (clock),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .div_wen  (div_wen),
    .div_wdata(div_wdata),
    .stop2    (stop2),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .tx       (tx),
    .busy     (busy),
    .level    (level)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // Expected line levels of one frame, one entry per clock.
  task automatic model_frame(input logic [7:0] b, input int div, input bit s2,
                             input bit par_en, input bit par_odd);
    int bp;
    bp = div + 1;
    repeat (bp) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (bp) exp_q.push_back(b[i]);
    if (par_en) repeat (bp) exp_q.push_back((^b) ^ par_odd);
    repeat (s2 ? 2 * bp : bp) exp_q.push_back(1'b1);
  endtask

  task automatic model_idle(input int n);
    repeat (n) exp_q.push_back(1'b1);
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      cap_tx[i]    = tx;
      cap_busy[i]  = busy;
      cap_rdy[i]   = in_ready;
      cap_level[i] = level;
    end
  endtask

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size(); i++) if (cap_tx[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  task automatic set_div(input int v);
    div_wen   = 1'b1;
    div_wdata = 16'(v);
    @(posedge clock);
    #1 div_wen = 1'b0;
  endtask

  task automatic push_one(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] b;
    int d;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || level !== 3'd0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: tx=%b busy=%b level=%0d in_ready=%b, want 1 0 0 1",
                 i, tx, busy, level, in_ready);
      end
    end
    // Default divisor is only observable through the bit period.
    sync();
    b = 8'($urandom);
    exp_q.delete();
    model_idle(2);
    model_frame(b, 172, 1'b0, 1'b0, 1'b0);
    model_idle(2);
    fork
      push_one(b);
      begin @(posedge clock); capture(exp_q.size()); end
    join
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL default_div: sample %0d tx=%b, want %b", d, cap_tx[d], exp_q[d]);
    end
  endtask

  task automatic test_basic();
    int d;
    bit ok;
    sync();
    set_div(3);
    stop2 = 1'b0;
    exp_q.delete();
    model_idle(2);
    model_frame(8'h55, 3, 1'b0, 1'b0, 1'b0);
    model_idle(3);
    fork
      push_one(8'h55);
      begin @(posedge clock); capture(exp_q.size()); end
    join
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL basic_wave: sample %0d tx=%b, want %b", d, cap_tx[d], exp_q[d]);
    end
    checks++;
    if (cap_level[0] !== 3'd1) begin
      errors++;
      $display("FAIL basic_level: level=%0d after push, want 1", cap_level[0]);
    end
    ok = 1'b1;
    for (int i = 1; i <= 40; i++) if (cap_busy[i] !== 1'b1) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_busy_high: busy dropped during frame, want 1");
    end
    checks++;
    if (cap_busy[44] !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_low: busy=%b after frame, want 0", cap_busy[44]);
    end
  endtask

  task automatic test_random();
    int d, dv;
    bit s;
    logic [7:0] b;
    for (int it = 0; it < 8; it++) begin
      dv = $urandom_range(0, 5);
      s  = 1'($urandom_range(0, 1));
      b  = 8'($urandom);
      repeat ($urandom_range(1, 4)) sync();
      set_div(dv);
      stop2 = s;
      exp_q.delete();
      model_idle(2);
      model_frame(b, dv, s, 1'b0, 1'b0);
      model_idle(2);
      fork
        push_one(b);
        begin @(posedge clock); capture(exp_q.size()); end
      join
      d = first_diff();
      checks++;
      if (d >= 0) begin
        errors++;
        $display("FAIL random_wave it%0d b=%h div=%0d s2=%0d: sample %0d tx=%b, want %b",
                 it, b, dv, s, d, cap_tx[d], exp_q[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [6];
    int acc [6];
    int d, t;
    bit rdy, timeout;
    sync();
    set_div(1);
    stop2 = 1'b0;
    timeout = 1'b0;
    exp_q.delete();
    model_idle(2);
    for (int k = 0; k < 6; k++) begin
      bytes[k] = 8'($urandom);
      model_frame(bytes[k], 1, 1'b0, 1'b0, 1'b0);
    end
    model_idle(4);
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          in_valid = 1'b1;
          in_data  = bytes[k];
          t = 0;
          do begin
            rdy = in_ready;
            @(posedge clock);
            #1 t++;
          end while (!rdy && t < 200);
          if (!rdy) timeout = 1'b1;
          acc[k] = cyc;
        end
        in_valid = 1'b0;
      end
      begin @(posedge clock); capture(exp_q.size()); end
    join
    checks++;
    if (timeout) begin
      errors++;
      $display("FAIL b2b_timeout: push not accepted within 200 cycles, want acceptance");
    end
    // Frame period 20 clocks; the 6th push waits out the pop edge because the FIFO is full there.
    for (int k = 1; k < 6; k++) begin
      t = (k < 5) ? acc[0] + k : acc[0] + 22;
      checks++;
      if (acc[k] !== t) begin
        errors++;
        $display("FAIL b2b_accept%0d: accepted at cycle %0d, want %0d", k, acc[k], t);
      end
    end
    checks++;
    if (cap_level[4] !== 3'd4 || cap_rdy[4] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full: level=%0d in_ready=%b, want 4 0", cap_level[4], cap_rdy[4]);
    end
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL b2b_wave: sample %0d tx=%b, want %b", d, cap_tx[d], exp_q[d]);
    end
  endtask

  task automatic test_stop2();
    logic [7:0] b1;
    int d;
    bit ok;
    sync();
    set_div(2);
    stop2 = 1'b1;
    b1 = 8'($urandom);
    exp_q.delete();
    model_idle(2);
    model_frame(8'hFF, 2, 1'b1, 1'b0, 1'b0);
    model_frame(b1, 2, 1'b0, 1'b0, 1'b0);
    model_idle(3);
    fork
      begin
        push_one(8'hFF);
        push_one(b1);
        repeat (8) @(posedge clock);
        #1 stop2 = 1'b0;
      end
      begin @(posedge clock); capture(exp_q.size()); end
    join
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL stop2_wave: sample %0d tx=%b, want %b", d, cap_tx[d], exp_q[d]);
    end
    ok = (cap_tx[35] === 1'b0);
    for (int i = 29; i < 35; i++) if (cap_tx[i] !== 1'b1) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stop2_len: stop span not 6 high clocks then start (tx[35]=%b), want 6",
               cap_tx[35]);
    end
  endtask

  task automatic test_div_change();
    logic [7:0] b0, b1;
    int d;
    sync();
    set_div(3);
    stop2 = 1'b0;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    exp_q.delete();
    model_idle(2);
    model_frame(b0, 3, 1'b0, 1'b0, 1'b0);
    model_frame(b1, 7, 1'b0, 1'b0, 1'b0);
    model_idle(3);
    fork
      begin
        push_one(b0);
        push_one(b1);
        repeat (8) @(posedge clock);
        #1 set_div(7);
      end
      begin @(posedge clock); capture(exp_q.size()); end
    join
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL div_change_wave: sample %0d tx=%b, want %b", d, cap_tx[d], exp_q[d]);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int d;
    for (int po = 0; po < 2; po++) begin
      sync();
      set_div(1);
      stop2 = 1'b0;
      parity_odd = 1'(po);
      exp_q.delete();
      model_idle(2);
      model_frame(8'h07, 1, 1'b0, 1'b1, 1'(po));
      model_idle(2);
      fork
        push_one(8'h07);
        begin @(posedge clock); capture(exp_q.size()); end
      join
      d = first_diff();
      checks++;
      if (d >= 0) begin
        errors++;
        $display("FAIL parity_wave odd=%0d: sample %0d tx=%b, want %b", po, d, cap_tx[d], exp_q[d]);
      end
      checks++;
      if (cap_tx[20] !== ((po == 0) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL parity_bit odd=%0d: tx=%b, want %b", po, cap_tx[20], (po == 0));
      end
    end
  endtask
`endif

  task automatic test_reset_abort();
    sync();
    set_div(3);
    stop2 = 1'b0;
    push_one(8'h00);
    push_one(8'h3c);
    push_one(8'ha5);
    repeat (10) @(posedge clock);
    #2;
    checks++;
    if (tx !== 1'b0 || level === 3'd0) begin
      errors++;
      $display("FAIL abort_pre: tx=%b level=%0d, want tx 0 and level nonzero", tx, level);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || level !== 3'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_reset: tx=%b level=%0d busy=%b in_ready=%b, want 1 0 0 1",
               tx, level, busy, in_ready);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (20) @(negedge clock);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_after: tx=%b busy=%b, want 1 0", tx, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_stop2();
    test_div_change();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
